// File: rtl/desorption_ramp_sequencer.sv
// Desorption heater profile sequencer: ramp up, hold, ramp down.
// Drives the duty/enable inputs of the PWM core from a pad start.
module desorption_ramp_sequencer #(
    parameter int DUTY_W   = 8,
    parameter int HOLD_W   = 8,
    parameter int TICK_DIV = 1000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DUTY_W-1:0] target_i,
    input  logic [DUTY_W-1:0] step_i,
    input  logic [HOLD_W-1:0] hold_i,
    output logic [DUTY_W-1:0] duty_o,
    output logic              pwm_en_o,
    output logic [2:0]        phase_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_DONE      = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic start_s1_q, start_s2_q, start_d_q;
    logic abort_s1_q, abort_s2_q;

    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic [DUTY_W-1:0] step_q, step_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic              pwm_en_q, pwm_en_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              start_rise;
    logic              abort_s;
    logic              busy;
    logic              tick;
    logic [DUTY_W:0]   sum;

    // Pad synchronisers. The start chain resets to 1 so a start that
    // is already high when reset releases is not seen as a rising edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            start_s1_q <= 1'b1;
            start_s2_q <= 1'b1;
            start_d_q  <= 1'b1;
            abort_s1_q <= 1'b0;
            abort_s2_q <= 1'b0;
        end else begin
            start_s1_q <= start_i;
            start_s2_q <= start_s1_q;
            start_d_q  <= start_s2_q;
            abort_s1_q <= abort_i;
            abort_s2_q <= abort_s1_q;
        end
    end

    assign start_rise = start_s2_q & ~start_d_q;
    assign abort_s    = abort_s2_q;

    assign busy = (state_q == ST_RAMP_UP) ||
                  (state_q == ST_HOLD) ||
                  (state_q == ST_RAMP_DOWN);

    assign tick = busy && (tick_cnt_q == TICK_LAST);

    // Saturation is decided on the widened sum so the ramp never wraps.
    assign sum = {1'b0, duty_q} + {1'b0, step_q};

    // Next-state, duty profile and prescaler control.
    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        target_d   = target_q;
        step_d     = step_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        if (busy) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        end else begin
            tick_cnt_d = '0;
        end

        unique case (state_q)
            ST_IDLE: begin
                duty_d = '0;
                if (start_rise && !abort_s) begin
                    target_d   = target_i;
                    step_d     = step_i;
                    hold_d     = hold_i;
                    tick_cnt_d = '0;
                    if (step_i == '0) begin
                        state_d = ST_FAULT;
                    end else if (target_i == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RAMP_UP;
                    end
                end
            end
            ST_RAMP_UP: begin
                if (abort_s) begin
                    state_d    = ST_RAMP_DOWN;
                    tick_cnt_d = '0;
                end else if (tick) begin
                    if (sum >= {1'b0, target_q}) begin
                        duty_d     = target_q;
                        hold_cnt_d = hold_q;
                        state_d    = ST_HOLD;
                    end else begin
                        duty_d = sum[DUTY_W-1:0];
                    end
                end
            end
            ST_HOLD: begin
                if (abort_s) begin
                    state_d    = ST_RAMP_DOWN;
                    tick_cnt_d = '0;
                end else if (tick) begin
                    if (hold_cnt_q == '0) begin
                        state_d = ST_RAMP_DOWN;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 1'b1;
                    end
                end
            end
            ST_RAMP_DOWN: begin
                if (tick) begin
                    if (duty_q <= step_q) begin
                        duty_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        duty_d = duty_q - step_q;
                    end
                end
            end
            ST_DONE: begin
                duty_d  = '0;
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                duty_d = '0;
                if (abort_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                duty_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        pwm_en_d = (state_d == ST_RAMP_UP) ||
                   (state_d == ST_HOLD) ||
                   (state_d == ST_RAMP_DOWN);
        done_d   = (state_d == ST_DONE);
        err_d    = (state_d == ST_FAULT);
    end

    // State, profile and registered output flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            duty_q     <= '0;
            target_q   <= '0;
            step_q     <= '0;
            hold_q     <= '0;
            hold_cnt_q <= '0;
            tick_cnt_q <= '0;
            pwm_en_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            target_q   <= target_d;
            step_q     <= step_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            pwm_en_q   <= pwm_en_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign duty_o   = duty_q;
    assign pwm_en_o = pwm_en_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign phase_o  = state_q;
    assign busy_o   = busy;

endmodule
